// File: rtl/simd_addsub_pipe_pkg.sv
// Shared definitions for the packed-lane add/subtract unit: opcode encoding,
// lane saturation constants and the popcount used by the saturation counter.
package simd_addsub_pipe_pkg;

  // Upper bounds for the helper functions below. Results are sliced down to
  // the real lane width / lane count by the caller.
  localparam int unsigned MAX_LANE_W = 64;
  localparam int unsigned MAX_LANES  = 64;

  // Operation select, shared with the instruction decoder.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  // Largest signed value of a lane: 0111..1 (low lane_w bits meaningful).
  function automatic logic [MAX_LANE_W-1:0] lane_sat_max(input int unsigned lane_w);
    logic [MAX_LANE_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_LANE_W; i++) begin
      if (i + 1 < lane_w) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  // Smallest signed value of a lane: 1000..0 (low lane_w bits meaningful).
  function automatic logic [MAX_LANE_W-1:0] lane_sat_min(input int unsigned lane_w);
    logic [MAX_LANE_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_LANE_W; i++) begin
      if (i + 1 == lane_w) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  // Number of set bits in a (zero-extended) lane flag vector.
  function automatic logic [31:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      cnt = cnt + {31'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/simd_addsub_pipe_addsub_lane.sv
// One two's-complement lane: raw add/subtract result truncated to the lane
// width, plus separate positive and negative signed-overflow indications.
module addsub_lane
  import simd_addsub_pipe_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  logic              sub_i,
  output logic [LANE_W-1:0] raw_o,
  output logic              pos_o,
  output logic              neg_o
);

  logic              cin;
  logic [LANE_W-1:0] bx;

  // Subtraction is A + ~B + 1; overflow is judged on the effective operand.
  always_comb begin
    cin   = (sub_i == OP_SUB);
    bx    = cin ? ~b_i : b_i;
    raw_o = a_i + bx + LANE_W'(cin);
    pos_o = !a_i[LANE_W-1] && !bx[LANE_W-1] &&  raw_o[LANE_W-1];
    neg_o =  a_i[LANE_W-1] &&  bx[LANE_W-1] && !raw_o[LANE_W-1];
  end

endmodule

// File: rtl/simd_addsub_pipe.sv
// Two-stage pipelined SIMD saturating adder/subtracter with valid/ready
// handshake and a saturating count of saturated lanes delivered downstream.
// Stage 1 holds raw lane sums and overflow flags; stage 2 is the output
// register holding the (optionally) saturated result.
module simd_addsub_pipe
  import simd_addsub_pipe_pkg::*;
#(
  parameter  int LANE_W = 4,
  parameter  int LANES  = 4,
  parameter  int CNT_W  = 16,
  localparam int DATA_W = LANE_W * LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  input  logic              sat_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic [LANES-1:0]  ovf,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  sat_count
);

  localparam logic [LANE_W-1:0] SAT_MAX = LANE_W'(lane_sat_max(LANE_W));
  localparam logic [LANE_W-1:0] SAT_MIN = LANE_W'(lane_sat_min(LANE_W));

  // Handshake
  logic s1_advance;
  logic in_fire;
  logic out_fire;

  // Combinational lane results from the operand inputs
  logic [DATA_W-1:0] lane_raw;
  logic [LANES-1:0]  lane_pos;
  logic [LANES-1:0]  lane_neg;

  // Stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_raw_q,   s1_raw_d;
  logic [LANES-1:0]  s1_pos_q,   s1_pos_d;
  logic [LANES-1:0]  s1_neg_q,   s1_neg_d;
  logic              s1_sat_q,   s1_sat_d;

  // Stage 2 (output) registers
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] sum_q,       sum_d;
  logic [LANES-1:0]  ovf_q,       ovf_d;
  logic              out_sat_q,   out_sat_d;

  // Saturation event counter
  logic [CNT_W-1:0]  sat_count_q, sat_count_d;
  logic [31:0]       sat_pop;
  logic [CNT_W+31:0] cnt_sum;

  // Saturated view of stage 1, feeding the output register
  logic [DATA_W-1:0] sat_sum;

  // Stage 1 may move on when the output register is empty or being drained.
  // in_ready depends only on registered state and out_ready, never in_valid.
  assign s1_advance = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;

  // Lane array: carries are confined to each instance.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      addsub_lane #(
        .LANE_W (LANE_W)
      ) u_lane (
        .a_i   (a[gi*LANE_W +: LANE_W]),
        .b_i   (b[gi*LANE_W +: LANE_W]),
        .sub_i (sub),
        .raw_o (lane_raw[gi*LANE_W +: LANE_W]),
        .pos_o (lane_pos[gi]),
        .neg_o (lane_neg[gi])
      );
    end
  endgenerate

  // Per-lane clamp applied between stage 1 and the output register.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_sat
      assign sat_sum[gi*LANE_W +: LANE_W] =
          !s1_sat_q      ? s1_raw_q[gi*LANE_W +: LANE_W] :
          s1_pos_q[gi]   ? SAT_MAX :
          s1_neg_q[gi]   ? SAT_MIN :
                           s1_raw_q[gi*LANE_W +: LANE_W];
    end
  endgenerate

  // Stage 1 next state: capture on accept, empty when handed to stage 2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_raw_d   = s1_raw_q;
    s1_pos_d   = s1_pos_q;
    s1_neg_d   = s1_neg_q;
    s1_sat_d   = s1_sat_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_raw_d   = lane_raw;
      s1_pos_d   = lane_pos;
      s1_neg_d   = lane_neg;
      s1_sat_d   = sat_en;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: load only when stage 1 advances, so a stalled
  // output keeps sum/ovf/out_valid exactly as they were.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    out_sat_d   = out_sat_q;
    if (s1_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d     = sat_sum;
        ovf_d     = s1_pos_q | s1_neg_q;
        out_sat_d = s1_sat_q;
      end
    end
  end

  // Counter next state: add saturated lanes on delivery, clamp at all-ones,
  // and let a clear take priority over a coincident increment.
  always_comb begin
    sat_pop     = popcount(MAX_LANES'(ovf_q));
    cnt_sum     = {32'd0, sat_count_q} + {{CNT_W{1'b0}}, sat_pop};
    sat_count_d = sat_count_q;
    if (clr_count) begin
      sat_count_d = '0;
    end else if (out_fire && out_sat_q) begin
      if (cnt_sum[CNT_W+31:CNT_W] != '0) begin
        sat_count_d = '1;
      end else begin
        sat_count_d = cnt_sum[CNT_W-1:0];
      end
    end
  end

  // Stage 1 registers; reset discards any beat in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_raw_q   <= '0;
      s1_pos_q   <= '0;
      s1_neg_q   <= '0;
      s1_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_raw_q   <= s1_raw_d;
      s1_pos_q   <= s1_pos_d;
      s1_neg_q   <= s1_neg_d;
      s1_sat_q   <= s1_sat_d;
    end
  end

  // Output registers; reset clears the visible result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Saturation event counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// Self-checking bench for simd_addsub_pipe (4 lanes x 4 bits, 4-bit counter).
// A queue-based model predicts every delivered beat from signed integer
// arithmetic; directed beats additionally pin literal results.
module tb_simd_addsub_pipe;

  localparam int LW = 4;
  localparam int NL = 4;
  localparam int DW = LW * NL;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          sub = 1'b0;
  logic          sat_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] sum;
  logic [NL-1:0] ovf;
  logic          clr_count = 1'b0;
  logic [CW-1:0] sat_count;

  simd_addsub_pipe #(
    .LANE_W (LW),
    .LANES  (NL),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf),
    .clr_count (clr_count),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: each lane is a signed integer; overflow is simply leaving the
  // signed range, and saturation clamps to that range.
  function automatic void ref_beat(input logic [DW-1:0] ra, input logic [DW-1:0] rb,
                                   input logic rsub, input logic rsat,
                                   output logic [DW-1:0] rs, output logic [NL-1:0] ro);
    int av, bv, r, hi, lo;
    hi = (1 << (LW - 1)) - 1;
    lo = -(1 << (LW - 1));
    rs = '0;
    ro = '0;
    for (int i = 0; i < NL; i++) begin
      av = int'($signed(ra[i*LW +: LW]));
      bv = int'($signed(rb[i*LW +: LW]));
      r  = rsub ? av - bv : av + bv;
      if (r > hi) begin
        ro[i] = 1'b1;
        if (rsat) r = hi;
      end else if (r < lo) begin
        ro[i] = 1'b1;
        if (rsat) r = lo;
      end
      rs[i*LW +: LW] = r[LW-1:0];
    end
  endfunction

  typedef struct {
    logic [DW-1:0] s;
    logic [NL-1:0] o;
    logic          sat;
    int            acc;
  } beat_t;

  beat_t q[$];
  int    mcnt = 0;

  // Compare process: checks outputs against the model each cycle, then
  // advances the model by what will happen at the coming rising edge.
  always @(negedge clk) begin : monitor
    logic  exp_ov, exp_rdy, fire, acc;
    beat_t nb;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_sat_count", sat_count, 0);
      q.delete();
      mcnt = 0;
    end else begin
      exp_ov  = (q.size() > 0) && (cyc - q[0].acc >= 2);
      exp_rdy = (q.size() < 2) || out_ready;
      chk("m_out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("m_sum", sum, q[0].s);
        chk("m_ovf", ovf, q[0].o);
      end
      chk("m_in_ready", in_ready, exp_rdy);
      chk("m_sat_count", sat_count, mcnt);
      fire = exp_ov && out_ready;
      acc  = in_valid && exp_rdy;
      if (clr_count) begin
        mcnt = 0;
      end else if (fire && q[0].sat) begin
        mcnt = mcnt + $countones(q[0].o);
        if (mcnt > CNT_MAX) mcnt = CNT_MAX;
      end
      if (fire) begin
        $display("beat out sum=%h ovf=%b sat=%0b cnt_next=%0d", q[0].s, q[0].o, q[0].sat, mcnt);
        void'(q.pop_front());
      end
      if (acc) begin
        ref_beat(a, b, sub, sat_en, nb.s, nb.o);
        nb.sat = sat_en;
        nb.acc = cyc;
        q.push_back(nb);
      end
    end
  end

  // Single beat through an empty pipe with literal expectations.
  // Called at posedge+1; ecnt < 0 skips the counter check.
  task automatic run_beat(input string name, input logic [DW-1:0] ta, input logic [DW-1:0] tb_,
                          input logic ts, input logic tsat,
                          input logic [DW-1:0] es, input logic [NL-1:0] eo,
                          input int ecnt, input logic tclr);
    out_ready = 1'b1;
    a = ta; b = tb_; sub = ts; sat_en = tsat; in_valid = 1'b1;
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_sum"}, sum, es);
    chk({name, "_ovf"}, ovf, eo);
    clr_count = tclr;
    @(posedge clk); #1;
    clr_count = 1'b0;
    if (ecnt >= 0) chk({name, "_cnt"}, sat_count, ecnt);
  endtask

  logic [DW-1:0] sa [4] = '{16'h1234, 16'h0007, 16'h8888, 16'h0000};
  logic [DW-1:0] sb [4] = '{16'h1111, 16'h0001, 16'h1111, 16'h8888};
  logic          ss [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  // Accept beats first..last-1 from the table, holding out_ready as given.
  task automatic push_beats(input int first, input int last);
    int  idx, guard;
    logic r;
    idx = first;
    guard = 0;
    while (idx < last && guard < 20) begin
      a = sa[idx]; b = sb[idx]; sub = ss[idx]; sat_en = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      if (r) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("push_timeout", idx, last);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_sum", sum, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    run_beat("add_plain", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 4'b0000, 0, 1'b0);
    run_beat("add_sat",   16'h0007, 16'h0001, 1'b0, 1'b1, 16'h0007, 4'b0001, 1, 1'b0);
    run_beat("add_wrap",  16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 4'b0001, 1, 1'b0);
    run_beat("sub_neg",   16'h8888, 16'h1111, 1'b1, 1'b1, 16'h8888, 4'b1111, 5, 1'b0);
    run_beat("sub_pos",   16'h0000, 16'h8888, 1'b1, 1'b1, 16'h7777, 4'b1111, 9, 1'b0);
    run_beat("cnt_13",    16'h8888, 16'h1111, 1'b1, 1'b1, 16'h8888, 4'b1111, 13, 1'b0);
    run_beat("cnt_clamp", 16'h8888, 16'h1111, 1'b1, 1'b1, 16'h8888, 4'b1111, 15, 1'b0);
    run_beat("cnt_hold",  16'h8888, 16'h1111, 1'b1, 1'b1, 16'h8888, 4'b1111, 15, 1'b0);
    run_beat("cnt_clr",   16'h8888, 16'h1111, 1'b1, 1'b1, 16'h8888, 4'b1111, 0, 1'b1);

    // Stall: two beats buffer, output holds, inputs are ignored.
    out_ready = 1'b0;
    push_beats(0, 2);
    in_valid = 1'b1;
    repeat (4) begin
      a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", sum, 16'h2345);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    push_beats(2, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_valid", out_valid, 0);
    chk("drain_cnt", sat_count, 9);

    // Random traffic against the model.
    repeat (400) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a         = 16'($urandom);
      b         = 16'($urandom);
      sub       = 1'($urandom);
      sat_en    = 1'($urandom);
      clr_count = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr_count = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_drain", out_valid, 0);

    // Asynchronous reset with both stages occupied.
    run_beat("pre_rst", 16'h8888, 16'h1111, 1'b1, 1'b1, 16'h8888, 4'b1111, -1, 1'b0);
    out_ready = 1'b0;
    push_beats(0, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sum", sum, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_cnt", sat_count, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    run_beat("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 4'b0000, 0, 1'b0);
    chk("post_rst_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
